// File: rtl/fetch_mem_ctrl.sv
// rtl/fetch_mem_ctrl.sv - single-port memory master: PC, instruction prefetch queue, data access arbitration
// Data accesses always win the port; fetches are issued only when a queue slot is reserved.
module fetch_mem_ctrl #(
  parameter int AW       = 13,
  parameter int DW       = 18,
  parameter int FQ_DEPTH = 2,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_vld,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_vld,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_rdy,
  input  logic          dreq_vld,
  input  logic          dreq_we,
  input  logic [AW-1:0] dreq_addr,
  input  logic [DW-1:0] dreq_wdata,
  output logic          dreq_rdy,
  output logic          dresp_vld,
  output logic [DW-1:0] dresp_data,
  output logic [AW-1:0] mem_address,
  output logic          mem_re_en,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout
);

  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IF_NONE, IF_FETCH, IF_DREAD} inflight_t;

  inflight_t       r_inflight, w_inflight_nxt;
  logic [AW-1:0]   r_pc;
  logic [AW-1:0]   r_fetch_pc;
  logic [DW-1:0]   r_q_data [FQ_DEPTH];
  logic [AW-1:0]   r_q_pc   [FQ_DEPTH];
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_data_op;
  logic            w_fetch;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_reserved;

  // Slots already spoken for: queued entries plus a fetch whose word returns this cycle.
  assign w_reserved = r_count + {{(CW-1){1'b0}}, (r_inflight == IF_FETCH)};
  assign w_data_op  = dreq_vld & ~rst;
  assign w_fetch    = ~rst & ~dreq_vld & ~redirect_vld & (w_reserved < CW'(FQ_DEPTH));
  // A redirect drops the returning fetch word and any pop in the same cycle.
  assign w_push     = (r_inflight == IF_FETCH) & ~redirect_vld;
  assign w_pop      = (r_count != '0) & instr_rdy & ~redirect_vld;

  assign dreq_rdy    = w_data_op;
  assign mem_address = w_data_op ? dreq_addr : r_pc;
  assign mem_re_en   = (w_data_op & ~dreq_we) | w_fetch;
  assign mem_wr_en   = w_data_op & dreq_we;
  assign mem_datain  = dreq_wdata;

  assign dresp_vld   = (r_inflight == IF_DREAD);
  assign dresp_data  = mem_dataout;

  assign instr_vld   = (r_count != '0);
  assign instr_data  = r_q_data[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];

  always_comb begin
    w_inflight_nxt = IF_NONE;
    if (w_data_op && !dreq_we) begin
      w_inflight_nxt = IF_DREAD;
    end else if (w_fetch) begin
      w_inflight_nxt = IF_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= IF_NONE;
    end else begin
      r_inflight <= w_inflight_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= AW'(RESET_PC);
      r_fetch_pc <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      if (redirect_vld) begin
        r_pc <= redirect_pc;
      end else if (w_fetch) begin
        r_pc <= r_pc + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_fetch) begin
        r_fetch_pc <= r_pc;
      end
      if (w_push) begin
        r_q_data[r_wr_ptr] <= mem_dataout;
        r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      end
      if (redirect_vld) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, w_push};
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, w_pop};
        r_count  <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// tb/tb_fetch_mem_ctrl.sv - directed self-checking bench for fetch_mem_ctrl
// Behavioural memory with one-cycle read latency sits behind the DUT.
module tb_fetch_mem_ctrl;

  localparam int AW = 13;
  localparam int DW = 18;

  localparam logic [DW-1:0] I_LOAD20  = 18'b001010000000010100;
  localparam logic [DW-1:0] I_ADD21   = 18'b000100000000010101;
  localparam logic [DW-1:0] I_STORE22 = 18'b001110000000010110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_vld = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_vld;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_rdy = 1'b0;
  logic          dreq_vld = 1'b0;
  logic          dreq_we = 1'b0;
  logic [AW-1:0] dreq_addr = '0;
  logic [DW-1:0] dreq_wdata = '0;
  logic          dreq_rdy;
  logic          dresp_vld;
  logic [DW-1:0] dresp_data;
  logic [AW-1:0] mem_address;
  logic          mem_re_en;
  logic          mem_wr_en;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_mem_ctrl #(.AW(AW), .DW(DW), .FQ_DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .instr_vld(instr_vld), .instr_data(instr_data), .instr_pc(instr_pc), .instr_rdy(instr_rdy),
    .dreq_vld(dreq_vld), .dreq_we(dreq_we), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dreq_rdy(dreq_rdy), .dresp_vld(dresp_vld), .dresp_data(dresp_data),
    .mem_address(mem_address), .mem_re_en(mem_re_en), .mem_wr_en(mem_wr_en),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_address] <= mem_datain;
    if (mem_re_en) mem_dataout <= mem[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance until the queue head is valid and compare it; the head pops if instr_rdy is high.
  task automatic wait_instr(input string tag, input logic [AW-1:0] exp_pc, input logic [DW-1:0] exp_data);
    bit found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      #1;
      if (instr_vld) begin
        check({tag, "_pc"}, 32'(instr_pc), 32'(exp_pc));
        check({tag, "_data"}, 32'(instr_data), 32'(exp_data));
        found = 1;
      end
    end
    if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0]  = I_LOAD20;
    mem[1]  = I_ADD21;
    mem[2]  = I_STORE22;
    mem[3]  = 18'h03333;
    mem[7]  = 18'h01234;
    mem[16] = 18'h10016;
    mem[17] = 18'h10017;
    mem[18] = 18'h10018;
    mem[19] = 18'h10019;
    mem[20] = 18'd42;

    // reset: all outputs low even with a pending data request
    tick();
    dreq_vld = 1'b1;
    dreq_we  = 1'b1;
    #1;
    check("rst_instr_vld", 32'(instr_vld), 32'd0);
    check("rst_dreq_rdy", 32'(dreq_rdy), 32'd0);
    check("rst_re_en", 32'(mem_re_en), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_dresp_vld", 32'(dresp_vld), 32'd0);

    // T1: in-order stream from RESET_PC
    tick();
    dreq_vld  = 1'b0;
    dreq_we   = 1'b0;
    rst       = 1'b0;
    instr_rdy = 1'b1;
    #1;
    check("t1_first_addr", 32'(mem_address), 32'd0);
    check("t1_first_re", 32'(mem_re_en), 32'd1);
    wait_instr("t1_i0", 13'd0, I_LOAD20);
    wait_instr("t1_i1", 13'd1, I_ADD21);
    wait_instr("t1_i2", 13'd2, I_STORE22);

    // T2: stalled decode -> exactly two fetches, resume after pop
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 13'd16;
    instr_rdy    = 1'b0;
    #1;
    check("t2_redir_re", 32'(mem_re_en), 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      redirect_vld = 1'b0;
      #1;
      if (i == 0) check("t2_flushed", 32'(instr_vld), 32'd0);
      if (mem_re_en) cnt++;
    end
    check("t2_fetch_cnt", 32'(cnt), 32'd2);
    tick();
    instr_rdy = 1'b1;
    #1;
    check("t2_pop_re", 32'(mem_re_en), 32'd0);
    check("t2_head_pc", 32'(instr_pc), 32'd16);
    check("t2_head_data", 32'(instr_data), 32'h10016);
    tick();
    #1;
    check("t2_resume_re", 32'(mem_re_en), 32'd1);
    check("t2_resume_addr", 32'(mem_address), 32'd18);
    check("t2_head2_pc", 32'(instr_pc), 32'd17);

    // T3: load steals one cycle of the stream
    tick();
    dreq_vld  = 1'b1;
    dreq_we   = 1'b0;
    dreq_addr = 13'd20;
    #1;
    check("t3_rdy", 32'(dreq_rdy), 32'd1);
    check("t3_re", 32'(mem_re_en), 32'd1);
    check("t3_addr", 32'(mem_address), 32'd20);
    check("t3_wr", 32'(mem_wr_en), 32'd0);
    tick();
    dreq_vld = 1'b0;
    #1;
    check("t3_dresp_vld", 32'(dresp_vld), 32'd1);
    check("t3_dresp_data", 32'(dresp_data), 32'd42);
    check("t3_head_pc", 32'(instr_pc), 32'd18);
    check("t3_fetch_addr", 32'(mem_address), 32'd19);
    wait_instr("t3_i19", 13'd19, 18'h10019);
    wait_instr("t3_i20", 13'd20, 18'd42);

    // T4: store then load back
    tick();
    dreq_vld   = 1'b1;
    dreq_we    = 1'b1;
    dreq_addr  = 13'd22;
    dreq_wdata = 18'd45;
    #1;
    check("t4_wr", 32'(mem_wr_en), 32'd1);
    check("t4_re", 32'(mem_re_en), 32'd0);
    check("t4_addr", 32'(mem_address), 32'd22);
    check("t4_datain", 32'(mem_datain), 32'd45);
    tick();
    dreq_vld = 1'b0;
    #1;
    check("t4_wr_off", 32'(mem_wr_en), 32'd0);
    check("t4_no_dresp", 32'(dresp_vld), 32'd0);
    tick();
    dreq_vld = 1'b1;
    dreq_we  = 1'b0;
    #1;
    check("t4_ld_re", 32'(mem_re_en), 32'd1);
    tick();
    dreq_vld = 1'b0;
    #1;
    check("t4_ld_vld", 32'(dresp_vld), 32'd1);
    check("t4_ld_data", 32'(dresp_data), 32'd45);
    tick();
    #1;
    check("t4_pulse_end", 32'(dresp_vld), 32'd0);

    // T5: redirect kills in-flight pc3 with pc2 queued
    tick();
    instr_rdy    = 1'b0;
    redirect_vld = 1'b1;
    redirect_pc  = 13'd2;
    tick();
    redirect_vld = 1'b0;
    tick();
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 13'd7;
    #1;
    check("t5_queued_pc", 32'(instr_pc), 32'd2);
    check("t5_redir_re", 32'(mem_re_en), 32'd0);
    tick();
    redirect_vld = 1'b0;
    instr_rdy    = 1'b1;
    #1;
    check("t5_flushed", 32'(instr_vld), 32'd0);
    check("t5_fetch_addr", 32'(mem_address), 32'd7);
    wait_instr("t5_i7", 13'd7, 18'h01234);

    // T6: PC wrap, then reset during a load
    tick();
    instr_rdy    = 1'b0;
    redirect_vld = 1'b1;
    redirect_pc  = 13'd8191;
    tick();
    redirect_vld = 1'b0;
    #1;
    check("t6_addr_top", 32'(mem_address), 32'd8191);
    tick();
    #1;
    check("t6_addr_wrap", 32'(mem_address), 32'd0);
    check("t6_re_wrap", 32'(mem_re_en), 32'd1);
    tick();
    dreq_vld  = 1'b1;
    dreq_addr = 13'd20;
    #1;
    check("t6_ld_re", 32'(mem_re_en), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_dresp", 32'(dresp_vld), 32'd0);
    check("t6_rst_instr", 32'(instr_vld), 32'd0);
    check("t6_rst_rdy", 32'(dreq_rdy), 32'd0);
    check("t6_rst_re", 32'(mem_re_en), 32'd0);
    check("t6_rst_wr", 32'(mem_wr_en), 32'd0);
    tick();
    #1;
    check("t6_rst_dresp2", 32'(dresp_vld), 32'd0);
    tick();
    rst      = 1'b0;
    dreq_vld = 1'b0;
    #1;
    check("t6_post_addr", 32'(mem_address), 32'd0);
    check("t6_post_re", 32'(mem_re_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
